scmu_host_bridge: RTL and testbench
===================================

SCMU_HOST_BRIDGE -- requirements
Module: scmu_host_bridge

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 36, width of a write payload toward the SCMU.
REQ-002 Parameter DATA_OUT_WIDTH, default 32, width of a read result from the SCMU.
REQ-003 Parameter ADDR_IN_WIDTH, default 11, width of the SCMU address bus.
REQ-004 Parameter CMD_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-005 Parameter TIMEOUT_CYCLES, default 256, maximum read wait on empty before abort.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 cmd_valid  input  1  host command present.
REQ-009 cmd_ready  output  1  queue can accept; cmd_ready = queue not full.
REQ-010 cmd_write  input  1  1 = write, 0 = read.
REQ-011 cmd_addr  input  ADDR_IN_WIDTH  SCMU address.
REQ-012 cmd_data  input  DATA_IN_WIDTH  write payload; ignored for reads.
REQ-013 rsp_valid  output  1  read response present.
REQ-014 rsp_ready  input  1  host accepts response.
REQ-015 rsp_data  output  DATA_OUT_WIDTH  read result.
REQ-016 rsp_timeout  output  1  response is a timeout abort.
REQ-017 chip_en  output  1  SCMU select, high only during an issue cycle.
REQ-018 a_in  output  ADDR_IN_WIDTH  SCMU address.
REQ-019 data_in  output  DATA_IN_WIDTH  SCMU write data.
REQ-020 data_out  input  DATA_OUT_WIDTH  SCMU read data.
REQ-021 empty  input  1  SCMU output queue empty.
REQ-022 full  input  1  SCMU input queue full.
REQ-023 busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-024 Command accepted on cycle where cmd_valid && cmd_ready; stored in FIFO of CMD_DEPTH entries {write, addr, data}; no bypass, issue earliest the cycle after acceptance.
REQ-025 Simultaneous push and pop with queue full: cmd_ready is low, push refused; push and pop with queue partially full: occupancy unchanged.
REQ-026 FSM states IDLE, WR_WAIT, WR_ISSUE, RD_WAIT, RD_ISSUE, RD_CAPT, RSP.
REQ-027 IDLE: queue non-empty pops head; write -> WR_WAIT, read -> RD_WAIT.
REQ-028 WR_WAIT: full low -> WR_ISSUE; full high -> stay, no timeout.
REQ-029 WR_ISSUE: one cycle chip_en=1, a_in=addr, data_in=data; -> IDLE.
REQ-030 RD_WAIT: empty low -> RD_ISSUE; counter increments each cycle with empty high; counter reaching TIMEOUT_CYCLES-1 -> RSP with rsp_data=0, rsp_timeout=1.
REQ-031 RD_ISSUE: one cycle chip_en=1, a_in=addr, data_in=0; -> RD_CAPT.
REQ-032 RD_CAPT: register data_out into rsp_data, rsp_timeout=0; -> RSP.
REQ-033 RSP: rsp_valid=1, rsp_data/rsp_timeout stable until rsp_valid && rsp_ready; then -> IDLE.
REQ-034 Outside issue cycles chip_en=0, a_in=0, data_in=0 (all registered outputs).
REQ-035 Strict in-order: at most one command in flight; write never overtakes pending read.
REQ-036 Timeout counter cleared on entering RD_WAIT; width ceil(log2(TIMEOUT_CYCLES)).

Reset
REQ-037 rst high at a clock edge: FSM -> IDLE, queue emptied, counter 0.
REQ-038 During and after reset: cmd_ready=0 while rst high, then 1; rsp_valid=0, rsp_data=0, rsp_timeout=0, chip_en=0, a_in=0, data_in=0, busy=0.
REQ-039 Reset mid-operation discards queued and in-flight commands; no partial SCMU issue after reset edge.

Structure
REQ-040 Shared package holds FSM state enumeration and default widths (36/32/11) and TIMEOUT_CYCLES.
REQ-041 Command queue is one sub-module, scmu_cmd_fifo, parameterised by width and depth.

Verification
REQ-042 Write addr 11'h010 data 36'h0_1234_5678, full=0 -> next-but-one cycle chip_en=1, a_in=11'h010, data_in=36'h012345678 for exactly one cycle.
REQ-043 Write with full=1 for 10 cycles -> no chip_en pulse until cycle after full drops; then single issue.
REQ-044 Read addr 11'h7F0, empty drops after 5 cycles, data_out=32'hDEADBEEF -> rsp_valid=1, rsp_data=32'hDEADBEEF, rsp_timeout=0; held 3 cycles with rsp_ready=0.
REQ-045 Read with empty held high -> after 256 cycles rsp_valid=1, rsp_timeout=1, rsp_data=0, no chip_en pulse.
REQ-046 Push 5 commands back-to-back while blocked -> cmd_ready low after 4th; order of issues matches push order.
REQ-047 Assert rst during RD_WAIT with 3 queued -> next cycle all outputs at reset values, no further issues.

Source files
------------

// File: rtl/scmu_host_bridge_pkg.sv
// Shared definitions for the SCMU host bridge: default bus widths, read timeout
// and the bridge sequencing states.
package scmu_host_bridge_pkg;

    localparam int DEF_DATA_IN_WIDTH  = 36;
    localparam int DEF_DATA_OUT_WIDTH = 32;
    localparam int DEF_ADDR_IN_WIDTH  = 11;
    localparam int DEF_CMD_DEPTH      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_WR_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_ISSUE = 3'd4,
        ST_RD_CAPT  = 3'd5,
        ST_RSP      = 3'd6
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scmu_cmd_fifo.sv
// Synchronous command FIFO for the host bridge; DEPTH must be a power of two so
// the read/write pointers wrap naturally.
module scmu_cmd_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state is updated with <= so every flop samples pre-edge values,
    // independent of the order in which always_ff blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count alone decides
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/scmu_host_bridge.sv
// Host-side command bridge to the SCMU: queues host commands, issues them one at
// a time with full/empty flow control, and returns read results or timeouts.
module scmu_host_bridge
    import scmu_host_bridge_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int ADDR_IN_WIDTH  = DEF_ADDR_IN_WIDTH,
    parameter int CMD_DEPTH      = DEF_CMD_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_IN_WIDTH-1:0]  cmd_addr,
    input  logic [DATA_IN_WIDTH-1:0]  cmd_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_OUT_WIDTH-1:0] rsp_data,
    output logic                      rsp_timeout,
    output logic                      chip_en,
    output logic [ADDR_IN_WIDTH-1:0]  a_in,
    output logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic [DATA_OUT_WIDTH-1:0] data_out,
    input  logic                      empty,
    input  logic                      full,
    output logic                      busy
);

    localparam int CMD_W = 1 + ADDR_IN_WIDTH + DATA_IN_WIDTH;
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CMD_W-1:0]           fifo_wdata;
    logic [CMD_W-1:0]           fifo_rdata;
    logic [ADDR_IN_WIDTH-1:0]   cur_addr;
    logic [DATA_IN_WIDTH-1:0]   cur_data;
    logic [CNT_W-1:0]           wait_cnt;
    logic                       rd_timeout;
    logic                       chip_en_nxt;
    logic [ADDR_IN_WIDTH-1:0]   a_in_nxt;
    logic [DATA_IN_WIDTH-1:0]   data_in_nxt;
    logic                       rsp_valid_nxt;

    // Refuse commands while reset is asserted so nothing lands in a queue being cleared.
    assign cmd_ready  = !fifo_full && !rst;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign fifo_wdata = {cmd_write, cmd_addr, cmd_data};
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    scmu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held (no latches).
    always_comb begin
        state_nxt     = state;
        rd_timeout    = 1'b0;
        chip_en_nxt   = 1'b0;
        a_in_nxt      = '0;
        data_in_nxt   = '0;
        rsp_valid_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = fifo_rdata[CMD_W-1] ? ST_WR_WAIT : ST_RD_WAIT;
            end
            ST_WR_WAIT:  if (!full) state_nxt = ST_WR_ISSUE;
            ST_WR_ISSUE: state_nxt = ST_IDLE;
            ST_RD_WAIT: begin
                if (!empty) begin
                    state_nxt = ST_RD_ISSUE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt  = ST_RSP;
                    rd_timeout = 1'b1;
                end
            end
            ST_RD_ISSUE: state_nxt = ST_RD_CAPT;
            ST_RD_CAPT:  state_nxt = ST_RSP;
            ST_RSP:      if (rsp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase

        // SCMU pins are registered: drive them during the cycle spent in an issue state.
        if (state_nxt == ST_WR_ISSUE) begin
            chip_en_nxt = 1'b1;
            a_in_nxt    = cur_addr;
            data_in_nxt = cur_data;
        end else if (state_nxt == ST_RD_ISSUE) begin
            chip_en_nxt = 1'b1;
            a_in_nxt    = cur_addr;
        end
        rsp_valid_nxt = (state_nxt == ST_RSP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_addr    <= '0;
            cur_data    <= '0;
            wait_cnt    <= '0;
            chip_en     <= 1'b0;
            a_in        <= '0;
            data_in     <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            chip_en   <= chip_en_nxt;
            a_in      <= a_in_nxt;
            data_in   <= data_in_nxt;
            rsp_valid <= rsp_valid_nxt;

            if (fifo_pop) begin
                cur_addr <= fifo_rdata[ADDR_IN_WIDTH+DATA_IN_WIDTH-1:DATA_IN_WIDTH];
                cur_data <= fifo_rdata[DATA_IN_WIDTH-1:0];
            end

            // Held at zero outside RD_WAIT, so each read wait starts counting from 0.
            if (state != ST_RD_WAIT) begin
                wait_cnt <= '0;
            end else if (empty) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == ST_RD_CAPT) begin
                rsp_data    <= data_out;
                rsp_timeout <= 1'b0;
            end else if (rd_timeout) begin
                rsp_data    <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scmu_host_bridge.sv
// Self-checking bench for scmu_host_bridge: directed scenarios plus a randomized
// mix compared against a transaction-level model (expected issue/response queues).
module tb_scmu_host_bridge;

    localparam int DIW   = 36;
    localparam int DOW   = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 4;
    localparam int TMO   = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DIW-1:0]  cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DOW-1:0]  rsp_data;
    logic            rsp_timeout;
    logic            chip_en;
    logic [AW-1:0]   a_in;
    logic [DIW-1:0]  data_in;
    logic [DOW-1:0]  data_out = '0;
    logic            empty;
    logic            full;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic           use_fixed = 1'b0;
    logic [DOW-1:0] fixed_val = '0;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DIW-1:0] data;
        int             at;
    } issue_t;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [DIW-1:0] data;
    } exp_issue_t;

    issue_t         issue_q[$];
    exp_issue_t     exp_q[$];
    logic [DOW-1:0] exp_rsp[$];
    logic [DOW-1:0] got_rsp[$];

    scmu_host_bridge #(
        .DATA_IN_WIDTH  (DIW),
        .DATA_OUT_WIDTH (DOW),
        .ADDR_IN_WIDTH  (AW),
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .chip_en     (chip_en),
        .a_in        (a_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SCMU read data model: a read issued to address a returns scmu_f(a) next cycle.
    function automatic logic [DOW-1:0] scmu_f(input logic [AW-1:0] a);
        return {a, ~a, a[9:0]};
    endfunction

    always @(posedge clk) begin
        if (use_fixed)          data_out <= fixed_val;
        else if (chip_en === 1'b1) data_out <= scmu_f(a_in);
    end

    always @(negedge clk) begin
        if (chip_en === 1'b1) issue_q.push_back('{a_in, data_in, cyc});
    end

    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DIW-1:0] d,
                            output int acc);
        int bound = 400;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        checks++;
        if (bound == 0) begin
            errors++;
            $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready);
        end else begin
            exp_q.push_back('{a, w ? d : '0});
        end
        @(negedge clk);
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int bound = 400;
        while ((busy !== 1'b0 || rsp_valid !== 1'b0) && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        checks++;
        if (bound == 0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b required 0", tag, busy);
        end
        @(negedge clk);
    endtask

    task automatic get_rsp(input int hold, output logic [DOW-1:0] d, output logic t,
                           output int at);
        int bound = 600;
        d  = '0;
        t  = 1'b0;
        at = 0;
        rsp_ready = 1'b0;
        while (rsp_valid !== 1'b1 && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        checks++;
        if (bound == 0) begin
            errors++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1", rsp_valid);
        end else begin
            d  = rsp_data;
            t  = rsp_timeout;
            at = cyc;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_timeout !== t) begin
                    errors++;
                    $display("FAIL rsp_hold: valid=%b data=%h to=%b required 1 %h %b",
                             rsp_valid, rsp_data, rsp_timeout, d, t);
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rsp_drop: rsp_valid=%b required 0", rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_timeout, chip_en, busy} !== 5'b0 ||
            rsp_data !== '0 || a_in !== '0 || data_in !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b rv=%b to=%b ce=%b busy=%b rd=%h a=%h d=%h required all 0",
                     cmd_ready, rsp_valid, rsp_timeout, chip_en, busy, rsp_data, a_in, data_in);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_basic();
        int acc;
        int first = -1;
        int pulses = 0;
        bit quiet_ok = 1'b1;
        issue_q.delete();
        exp_q.delete();
        full = 1'b0;
        push_cmd(1'b1, 11'h010, 36'h0_1234_5678, acc);
        for (int i = 0; i < 8; i++) begin
            if (chip_en === 1'b1) begin
                pulses++;
                if (first < 0) first = cyc;
                checks++;
                if (a_in !== 11'h010 || data_in !== 36'h0_1234_5678) begin
                    errors++;
                    $display("FAIL wr_basic_bus: a_in=%h data_in=%h required 010 012345678", a_in, data_in);
                end
            end else if (a_in !== '0 || data_in !== '0) begin
                quiet_ok = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL wr_basic_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (first <= acc || first > acc + 3) begin
            errors++;
            $display("FAIL wr_basic_latency: issue at %0d, accepted %0d, required 1..3 later", first, acc);
        end
        checks++;
        if (!quiet_ok) begin
            errors++;
            $display("FAIL wr_basic_idle_bus: a_in/data_in nonzero outside issue, required 0");
        end
        wait_idle("wr_basic");
    endtask

    task automatic test_write_full();
        int acc;
        int early = 0;
        issue_q.delete();
        exp_q.delete();
        full = 1'b1;
        push_cmd(1'b1, 11'h155, 36'hA_5A5A_5A5A, acc);
        for (int i = 0; i < 10; i++) begin
            if (chip_en === 1'b1) early++;
            @(negedge clk);
        end
        checks++;
        if (early != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_full_blocked: pulses=%0d busy=%b required 0 1", early, busy);
        end
        full = 1'b0;
        @(negedge clk);
        checks++;
        if (chip_en !== 1'b1 || a_in !== 11'h155 || data_in !== 36'hA_5A5A_5A5A) begin
            errors++;
            $display("FAIL wr_full_issue: ce=%b a=%h d=%h required 1 155 a5a5a5a5a", chip_en, a_in, data_in);
        end
        @(negedge clk);
        checks++;
        if (chip_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_full_single: chip_en=%b required 0", chip_en);
        end
        wait_idle("wr_full");
        checks++;
        if (issue_q.size() != 1) begin
            errors++;
            $display("FAIL wr_full_count: issues=%0d required 1", issue_q.size());
        end
    endtask

    task automatic test_read_data();
        int acc;
        int at;
        int early = 0;
        logic [DOW-1:0] d;
        logic t;
        issue_q.delete();
        exp_q.delete();
        use_fixed = 1'b1;
        fixed_val = 32'hDEAD_BEEF;
        empty = 1'b1;
        push_cmd(1'b0, 11'h7F0, '0, acc);
        repeat (5) begin
            if (chip_en === 1'b1) early++;
            @(negedge clk);
        end
        empty = 1'b0;
        get_rsp(3, d, t, at);
        checks++;
        if (d !== 32'hDEAD_BEEF || t !== 1'b0) begin
            errors++;
            $display("FAIL rd_data_rsp: data=%h to=%b required deadbeef 0", d, t);
        end
        wait_idle("rd_data");
        checks++;
        if (early != 0 || issue_q.size() != 1) begin
            errors++;
            $display("FAIL rd_data_issue_count: early=%0d issues=%0d required 0 1", early, issue_q.size());
        end else begin
            checks++;
            if (issue_q[0].addr !== 11'h7F0 || issue_q[0].data !== '0) begin
                errors++;
                $display("FAIL rd_data_issue: a=%h d=%h required 7f0 0", issue_q[0].addr, issue_q[0].data);
            end
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_read_timeout();
        int acc;
        int at;
        logic [DOW-1:0] d;
        logic t;
        issue_q.delete();
        exp_q.delete();
        empty = 1'b1;
        push_cmd(1'b0, 11'h2A3, '0, acc);
        get_rsp(2, d, t, at);
        checks++;
        if (t !== 1'b1 || d !== '0) begin
            errors++;
            $display("FAIL rd_timeout_rsp: data=%h to=%b required 0 1", d, t);
        end
        checks++;
        if (at - acc < TMO || at - acc > TMO + 2) begin
            errors++;
            $display("FAIL rd_timeout_latency: %0d cycles required %0d..%0d", at - acc, TMO, TMO + 2);
        end
        empty = 1'b0;
        wait_idle("rd_timeout");
        checks++;
        if (issue_q.size() != 0) begin
            errors++;
            $display("FAIL rd_timeout_no_issue: issues=%0d required 0", issue_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [AW-1:0]  a;
        logic [63:0]    r64;
        issue_q.delete();
        exp_q.delete();
        full = 1'b1;
        push_cmd(1'b1, 11'h001, 36'h1_0000_0001, acc);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a   = AW'($urandom);
            r64 = {$urandom(), $urandom()};
            push_cmd(1'b1, a, r64[DIW-1:0], acc);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_after_4: cmd_ready=%b required 0", cmd_ready);
        end
        a   = AW'($urandom);
        r64 = {$urandom(), $urandom()};
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_data  = r64[DIW-1:0];
        repeat (3) @(negedge clk);
        full = 1'b0;
        push_cmd(1'b1, a, r64[DIW-1:0], acc);
        wait_idle("b2b");
        checks++;
        if (issue_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: issues=%0d required %0d", issue_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (issue_q[i].addr !== exp_q[i].addr || issue_q[i].data !== exp_q[i].data) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: a=%h d=%h required %h %h", i,
                             issue_q[i].addr, issue_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        bit a_done = 1'b0;
        bit finished = 1'b0;
        issue_q.delete();
        exp_q.delete();
        exp_rsp.delete();
        got_rsp.delete();
        fork
            begin
                int acc;
                logic w;
                logic [AW-1:0] a;
                logic [63:0]   r64;
                for (int i = 0; i < 40; i++) begin
                    w   = 1'($urandom);
                    a   = AW'($urandom);
                    r64 = {$urandom(), $urandom()};
                    if (!w) exp_rsp.push_back(scmu_f(a));
                    push_cmd(w, a, r64[DIW-1:0], acc);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                a_done = 1'b1;
            end
            begin
                for (int k = 0; k < 5000 && !finished; k++) begin
                    @(negedge clk);
                    full      = ($urandom_range(0, 2) == 0);
                    empty     = ($urandom_range(0, 3) == 0);
                    rsp_ready = 1'($urandom);
                    if (rsp_valid === 1'b1 && rsp_ready) got_rsp.push_back(rsp_data);
                    if (a_done && busy === 1'b0 && rsp_valid === 1'b0) finished = 1'b1;
                end
            end
        join
        full      = 1'b0;
        empty     = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL rand_drain: bridge still busy=%b required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (issue_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_issue_count: issues=%0d required %0d", issue_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (issue_q[i].addr !== exp_q[i].addr || issue_q[i].data !== exp_q[i].data) begin
                    errors++;
                    $display("FAIL rand_issue[%0d]: a=%h d=%h required %h %h", i,
                             issue_q[i].addr, issue_q[i].data, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        checks++;
        if (got_rsp.size() != exp_rsp.size()) begin
            errors++;
            $display("FAIL rand_rsp_count: responses=%0d required %0d", got_rsp.size(), exp_rsp.size());
        end else begin
            for (int i = 0; i < exp_rsp.size(); i++) begin
                checks++;
                if (got_rsp[i] !== exp_rsp[i]) begin
                    errors++;
                    $display("FAIL rand_rsp[%0d]: data=%h required %h", i, got_rsp[i], exp_rsp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int stray_rsp = 0;
        issue_q.delete();
        exp_q.delete();
        empty = 1'b1;
        full  = 1'b0;
        push_cmd(1'b0, 11'h321, '0, acc);
        for (int i = 0; i < 3; i++) push_cmd(1'b1, AW'(11'h100 + i), DIW'(i + 1), acc);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: busy=%b cmd_ready=%b required 1 1", busy, cmd_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_timeout, chip_en, busy} !== 5'b0 ||
            rsp_data !== '0 || a_in !== '0 || data_in !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: rdy=%b rv=%b to=%b ce=%b busy=%b rd=%h a=%h d=%h required all 0",
                     cmd_ready, rsp_valid, rsp_timeout, chip_en, busy, rsp_data, a_in, data_in);
        end
        rst   = 1'b0;
        empty = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) stray_rsp++;
        end
        checks++;
        if (issue_q.size() != 0 || stray_rsp != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_discard: issues=%0d rsp=%0d busy=%b rdy=%b required 0 0 0 1",
                     issue_q.size(), stray_rsp, busy, cmd_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        empty     = 1'b0;
        full      = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_write_full();
        test_read_data();
        test_read_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
